// File: rtl/local_velocity.sv
// Global-to-local velocity rotation: an iterative CORDIC produces cos/sin of the
// heading, then four sign-magnitude products are summed into the robot frame.
module local_velocity #(
  parameter int N_WIDTH     = 17,
  parameter int Q_WIDTH     = 8,
  parameter int CORDIC_ITER = 16
) (
  input  logic               LOCAL_VELOCITY_CLOCK_50,
  input  logic               LOCAL_VELOCITY_RESET_InLow,
  input  logic               LOCAL_VELOCITY_START_In,
  input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_VX_GLOBAL_InBus,
  input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_VY_GLOBAL_InBus,
  input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_WZ_GLOBAL_InBus,
  input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_THETA_InBus,
  output logic               LOCAL_VELOCITY_BUSY_Out,
  output logic               LOCAL_VELOCITY_DONE_Out,
  output logic               LOCAL_VELOCITY_OVF_Out,
  output logic [N_WIDTH-1:0] LOCAL_VELOCITY_VX_LOCAL_OutBus,
  output logic [N_WIDTH-1:0] LOCAL_VELOCITY_VY_LOCAL_OutBus,
  output logic [N_WIDTH-1:0] LOCAL_VELOCITY_WZ_LOCAL_OutBus
);
  localparam int M      = N_WIDTH - 1;
  localparam int CW     = 18;  // Q1.15 with headroom so |cos|,|sin| can reach 1.0
  localparam int AW     = 26;
  localparam int FRAC   = 15;
  localparam int PW     = M + 2;
  localparam int IW     = (CORDIC_ITER > 1) ? $clog2(CORDIC_ITER) : 1;
  localparam int ANG_SH = 16 - Q_WIDTH;
  localparam logic [M-1:0]         LIM_180 = M'(180 << Q_WIDTH);
  localparam logic [M-1:0]         LIM_90  = M'(90 << Q_WIDTH);
  localparam logic signed [CW-1:0] X_INIT  = CW'(19898);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROTATE, S_MULT, S_SUM} state_t;
  typedef struct packed {logic s; logic [CW-2:0] m;} trig_t;
  typedef struct packed {logic s; logic [PW-1:0] m;} prod_t;
  typedef struct packed {logic ovf; logic [N_WIDTH-1:0] word;} res_t;

  // atan(2^-i) in degrees with 16 fractional bits
  function automatic logic signed [AW-1:0] atan_deg(input logic [IW-1:0] i);
    case (int'(i))
      0:       atan_deg = 26'sd2949120;
      1:       atan_deg = 26'sd1740967;
      2:       atan_deg = 26'sd919879;
      3:       atan_deg = 26'sd466945;
      4:       atan_deg = 26'sd234379;
      5:       atan_deg = 26'sd117304;
      6:       atan_deg = 26'sd58666;
      7:       atan_deg = 26'sd29335;
      8:       atan_deg = 26'sd14668;
      9:       atan_deg = 26'sd7334;
      10:      atan_deg = 26'sd3667;
      11:      atan_deg = 26'sd1833;
      12:      atan_deg = 26'sd917;
      13:      atan_deg = 26'sd458;
      14:      atan_deg = 26'sd229;
      15:      atan_deg = 26'sd115;
      default: atan_deg = AW'(3754937 >> i);
    endcase
  endfunction

  function automatic trig_t to_sm(input logic signed [CW-1:0] v, input logic neg);
    logic signed [CW-1:0] t;
    trig_t r;
    t   = neg ? -v : v;
    r.s = t[CW-1];
    r.m = (CW-1)'(r.s ? -t : t);
    return r;
  endfunction

  function automatic prod_t mul_sm(input logic [N_WIDTH-1:0] v, input trig_t c);
    logic [M+CW-2:0] full;
    prod_t r;
    full = (M+CW-1)'(v[M-1:0]) * (M+CW-1)'(c.m);
    r.s  = v[M] ^ c.s;
    r.m  = PW'(full >> FRAC);
    return r;
  endfunction

  function automatic res_t sm_sum(input prod_t a, input prod_t b);
    logic [PW:0] mag;
    logic        sgn;
    res_t        r;
    if (a.s == b.s) begin
      mag = {1'b0, a.m} + {1'b0, b.m};
      sgn = a.s;
    end else if (a.m >= b.m) begin
      mag = {1'b0, a.m - b.m};
      sgn = a.s;
    end else begin
      mag = {1'b0, b.m - a.m};
      sgn = b.s;
    end
    r.ovf = (mag > (PW+1)'({M{1'b1}}));
    if (r.ovf) r.word = {sgn, {M{1'b1}}};
    else       r.word = {sgn & (mag != '0), M'(mag)};
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic [N_WIDTH-1:0]    vx_q, vx_d, vy_q, vy_d, wz_q, wz_d;
  logic                  neg_cos_q, neg_cos_d, neg_sin_q, neg_sin_d;
  logic signed [CW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [AW-1:0]  z_q, z_d;
  prod_t                 p_vc_q, p_vc_d, p_vs_q, p_vs_d, p_xs_q, p_xs_d, p_yc_q, p_yc_d;
  logic [N_WIDTH-1:0]    vx_l_q, vx_l_d, vy_l_q, vy_l_d, wz_l_q, wz_l_d;
  logic                  busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;

  logic [M-1:0]          th_clamp, th_red;
  logic signed [CW-1:0]  dx, dy;
  trig_t                 cos_sm, sin_sm;
  prod_t                 xs_neg;
  res_t                  rx, ry;

  always_comb begin
    // NOTE: every _d starts from its _q, so no branch of the case can infer a latch.
    state_d   = state_q;
    iter_d    = iter_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    wz_d      = wz_q;
    neg_cos_d = neg_cos_q;
    neg_sin_d = neg_sin_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    p_vc_d    = p_vc_q;
    p_vs_d    = p_vs_q;
    p_xs_d    = p_xs_q;
    p_yc_d    = p_yc_q;
    vx_l_d    = vx_l_q;
    vy_l_d    = vy_l_q;
    wz_l_d    = wz_l_q;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    th_clamp = (LOCAL_VELOCITY_THETA_InBus[M-1:0] > LIM_180) ? LIM_180
                                                              : LOCAL_VELOCITY_THETA_InBus[M-1:0];
    th_red   = (th_clamp > LIM_90) ? LIM_180 - th_clamp : th_clamp;
    dx       = x_q >>> iter_q;
    dy       = y_q >>> iter_q;
    cos_sm   = to_sm(x_q, neg_cos_q);
    sin_sm   = to_sm(y_q, neg_sin_q);
    xs_neg   = p_xs_q;
    xs_neg.s = ~p_xs_q.s;
    rx       = sm_sum(p_vc_q, p_vs_q);
    ry       = sm_sum(p_yc_q, xs_neg);

    case (state_q)
      // The DONE pulse is emitted while already in IDLE, so a held START restarts
      // on the very next edge and throughput stays at CORDIC_ITER+4 cycles.
      S_IDLE: if (LOCAL_VELOCITY_START_In) begin
        state_d = S_LOAD;
        busy_d  = 1'b1;
      end
      S_LOAD: begin
        vx_d      = LOCAL_VELOCITY_VX_GLOBAL_InBus;
        vy_d      = LOCAL_VELOCITY_VY_GLOBAL_InBus;
        wz_d      = LOCAL_VELOCITY_WZ_GLOBAL_InBus;
        neg_cos_d = (th_clamp > LIM_90);
        neg_sin_d = LOCAL_VELOCITY_THETA_InBus[M];
        x_d       = X_INIT;
        y_d       = '0;
        z_d       = signed'(AW'(th_red) << ANG_SH);
        iter_d    = '0;
        ovf_d     = 1'b0;
        state_d   = S_ROTATE;
      end
      S_ROTATE: begin
        if (!z_q[AW-1]) begin
          x_d = x_q - dy;
          y_d = y_q + dx;
          z_d = z_q - atan_deg(iter_q);
        end else begin
          x_d = x_q + dy;
          y_d = y_q - dx;
          z_d = z_q + atan_deg(iter_q);
        end
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(CORDIC_ITER - 1)) state_d = S_MULT;
      end
      S_MULT: begin
        p_vc_d  = mul_sm(vx_q, cos_sm);
        p_vs_d  = mul_sm(vy_q, sin_sm);
        p_xs_d  = mul_sm(vx_q, sin_sm);
        p_yc_d  = mul_sm(vy_q, cos_sm);
        state_d = S_SUM;
      end
      S_SUM: begin
        vx_l_d  = rx.word;
        vy_l_d  = ry.word;
        wz_l_d  = wz_q;
        ovf_d   = ovf_q | rx.ovf | ry.ovf;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge LOCAL_VELOCITY_CLOCK_50 or negedge LOCAL_VELOCITY_RESET_InLow) begin
    if (!LOCAL_VELOCITY_RESET_InLow) begin
      state_q   <= S_IDLE;
      iter_q    <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      wz_q      <= '0;
      neg_cos_q <= 1'b0;
      neg_sin_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      p_vc_q    <= '0;
      p_vs_q    <= '0;
      p_xs_q    <= '0;
      p_yc_q    <= '0;
      vx_l_q    <= '0;
      vy_l_q    <= '0;
      wz_l_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking, so every flop samples the pre-edge value of every other flop.
      state_q   <= state_d;
      iter_q    <= iter_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      wz_q      <= wz_d;
      neg_cos_q <= neg_cos_d;
      neg_sin_q <= neg_sin_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      p_vc_q    <= p_vc_d;
      p_vs_q    <= p_vs_d;
      p_xs_q    <= p_xs_d;
      p_yc_q    <= p_yc_d;
      vx_l_q    <= vx_l_d;
      vy_l_q    <= vy_l_d;
      wz_l_q    <= wz_l_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign LOCAL_VELOCITY_BUSY_Out        = busy_q;
  assign LOCAL_VELOCITY_DONE_Out        = done_q;
  assign LOCAL_VELOCITY_OVF_Out         = ovf_q;
  assign LOCAL_VELOCITY_VX_LOCAL_OutBus = vx_l_q;
  assign LOCAL_VELOCITY_VY_LOCAL_OutBus = vy_l_q;
  assign LOCAL_VELOCITY_WZ_LOCAL_OutBus = wz_l_q;
endmodule

// File: tb/tb_local_velocity.sv
// Directed checks of the global-to-local velocity transform: latency, rotation results,
// saturation, handshake rules and mid-operation reset.
module tb_local_velocity;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] vx_g = '0, vy_g = '0, wz_g = '0, th = '0;
  logic        busy, done, ovf;
  logic [16:0] vx_l, vy_l, wz_l;
  int          n_checks = 0;
  int          n_errors = 0;

  always #10 clk = ~clk;

  local_velocity dut (
    .LOCAL_VELOCITY_CLOCK_50        (clk),
    .LOCAL_VELOCITY_RESET_InLow     (rst_n),
    .LOCAL_VELOCITY_START_In        (start),
    .LOCAL_VELOCITY_VX_GLOBAL_InBus (vx_g),
    .LOCAL_VELOCITY_VY_GLOBAL_InBus (vy_g),
    .LOCAL_VELOCITY_WZ_GLOBAL_InBus (wz_g),
    .LOCAL_VELOCITY_THETA_InBus     (th),
    .LOCAL_VELOCITY_BUSY_Out        (busy),
    .LOCAL_VELOCITY_DONE_Out        (done),
    .LOCAL_VELOCITY_OVF_Out         (ovf),
    .LOCAL_VELOCITY_VX_LOCAL_OutBus (vx_l),
    .LOCAL_VELOCITY_VY_LOCAL_OutBus (vy_l),
    .LOCAL_VELOCITY_WZ_LOCAL_OutBus (wz_l)
  );

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (+-%0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int sm2i(input logic [16:0] w);
    return w[16] ? -int'(w[15:0]) : int'(w[15:0]);
  endfunction

  function automatic logic [16:0] i2sm(input int v);
    return {v < 0, 16'(v < 0 ? -v : v)};
  endfunction

  // Drives the operands and START; returns #1 after the sampling edge (edge 0).
  task automatic start_op(input logic [16:0] a_vx, a_vy, a_wz, a_th);
    @(negedge clk);
    vx_g  = a_vx;
    vy_g  = a_vy;
    wz_g  = a_wz;
    th    = a_th;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check({tag, ".timeout"}, 0, 1, 0);
  endtask

  task automatic check_res(input string tag, input int e_vx, input int e_vy,
                           input logic [16:0] e_wz, input int tol);
    check({tag, ".vx"}, sm2i(vx_l), e_vx, tol);
    check({tag, ".vy"}, sm2i(vy_l), e_vy, tol);
    check({tag, ".wz"}, int'(wz_l), int'(e_wz), 0);
    check({tag, ".negzero"}, int'(vx_l == 17'h10000) + int'(vy_l == 17'h10000), 0, 0);
  endtask

  task automatic run_op(input string tag, input logic [16:0] a_vx, a_vy, a_wz, a_th,
                        input int e_vx, input int e_vy, input int tol);
    int lat;
    start_op(a_vx, a_vy, a_wz, a_th);
    wait_done(tag, lat);
    check({tag, ".lat"}, lat, 19, 0);
    check_res(tag, e_vx, e_vy, a_wz, tol);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, cnt, first_k, second_k, done_k;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.vx", int'(vx_l), 0, 0);
    check("rst.vy", int'(vy_l), 0, 0);
    check("rst.wz", int'(wz_l), 0, 0);
    check("rst.busy", int'(busy), 0, 0);
    check("rst.done", int'(done), 0, 0);
    check("rst.ovf", int'(ovf), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0 deg: identity; latency, busy and one-cycle DONE
    start_op(17'h00100, 17'h00080, 17'h000A5, 17'h00000);
    check("t1.busy_load", int'(busy), 1, 0);
    wait_done("t1", lat);
    check("t1.lat", lat, 19, 0);
    check("t1.busy_done", int'(busy), 0, 0);
    check_res("t1", 256, 128, 17'h000A5, 2);
    check("t1.ovf", int'(ovf), 0, 0);
    @(posedge clk);
    #1;
    check("t1.done_pulse", int'(done), 0, 0);

    // Quadrant corners and heading clamp
    run_op("t2_p90", 17'h00100, 17'h00000, 17'h10123, 17'h05A00, 0, -256, 2);
    run_op("t3_180", 17'h00100, 17'h00100, 17'h00000, 17'h0B400, -256, -256, 2);
    run_op("t3_m90", 17'h00100, 17'h00100, 17'h00000, 17'h15A00, -256, 256, 2);
    run_op("clamp_p200", 17'h00100, 17'h00000, 17'h00000, 17'h0C800, -256, 0, 2);
    run_op("clamp_m200", 17'h00100, 17'h00000, 17'h00000, 17'h1C800, -256, 0, 2);
    // 30 deg, vx=-2.0, vy=1.0: vx_l=-2*0.866+0.5=-1.232, vy_l=1.0+0.866=1.866
    run_op("t30", 17'h10200, 17'h00100, 17'h00007, 17'h01E00, -315, 478, 2);

    // 45 deg with full-scale inputs: vx_l saturates, vy_l near zero
    start_op(17'h0FFFF, 17'h0FFFF, 17'h00000, 17'h02D00);
    wait_done("t4", lat);
    check("t4.vx_sat", int'(vx_l), 32'h0FFFF, 0);
    check("t4.vy", sm2i(vy_l), 0, 2);
    check("t4.ovf", int'(ovf), 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4.ovf_hold", int'(ovf), 1, 0);
    check("t4.vx_hold", int'(vx_l), 32'h0FFFF, 0);
    start_op(17'h00100, 17'h00080, 17'h00000, 17'h00000);
    @(posedge clk);
    #1;
    check("t4.ovf_clr_load", int'(ovf), 0, 0);
    wait_done("t4b", lat);
    check("t4b.ovf", int'(ovf), 0, 0);
    check_res("t4b", 256, 128, 17'h00000, 2);

    // START held high: two back-to-back operations, 20 cycles apart
    @(negedge clk);
    vx_g = 17'h00100; vy_g = 17'h00000; wz_g = 17'h00001; th = 17'h00000;
    start = 1'b1;
    cnt = 0; first_k = -1; second_k = -1;
    for (int k = 0; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (k == 21) start = 1'b0;
      if (done) begin
        cnt++;
        if (first_k < 0) first_k = k;
        else second_k = k;
      end
    end
    check("b2b.count", cnt, 2, 0);
    check("b2b.first", first_k, 19, 0);
    check("b2b.period", second_k - first_k, 20, 0);

    // START pulses at edges 3 and 10 and input changes mid-operation are ignored
    start_op(17'h00100, 17'h00000, 17'h00042, 17'h01E00);
    cnt = 0; done_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        vx_g = 17'h0FFFF; vy_g = 17'h0FFFF; wz_g = 17'h00099; th = 17'h05A00;
      end
      if (k == 2 || k == 9) start = 1'b1;
      if (k == 3 || k == 10) start = 1'b0;
      if (done) begin
        cnt++;
        done_k = k;
      end
    end
    check("t5.count", cnt, 1, 0);
    check("t5.lat", done_k, 19, 0);
    check_res("t5", 222, -128, 17'h00042, 2);

    // Reset at edge 8 aborts with no DONE; a later operation completes normally
    start_op(17'h00100, 17'h00080, 17'h00011, 17'h05A00);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6.vx", int'(vx_l), 0, 0);
    check("t6.vy", int'(vy_l), 0, 0);
    check("t6.wz", int'(wz_l), 0, 0);
    check("t6.busy", int'(busy), 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    check("t6.no_done", cnt, 0, 0);
    run_op("t6b", 17'h00100, 17'h00080, 17'h00033, 17'h00000, 256, 128, 2);

    // Randomised operands against a floating-point rotation
    for (int i = 0; i < 6; i++) begin
      int  rvx, rvy, rth, evx, evy;
      real thr, ex, ey;
      rvx = int'($urandom_range(1023, 0));
      rvy = int'($urandom_range(1023, 0));
      rth = int'($urandom_range(46080, 0));
      if ($urandom_range(1, 0) == 1) rvx = -rvx;
      if ($urandom_range(1, 0) == 1) rvy = -rvy;
      if ($urandom_range(1, 0) == 1) rth = -rth;
      thr = (real'(rth) / 256.0) * 3.14159265358979 / 180.0;
      ex  = real'(rvx) * $cos(thr) + real'(rvy) * $sin(thr);
      ey  = -real'(rvx) * $sin(thr) + real'(rvy) * $cos(thr);
      evx = $rtoi(ex + ((ex >= 0.0) ? 0.5 : -0.5));
      evy = $rtoi(ey + ((ey >= 0.0) ? 0.5 : -0.5));
      run_op("rand", i2sm(rvx), i2sm(rvy), 17'h00005, i2sm(rth), evx, evy, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
